// File: rtl/md_ctrl.sv
// Multiply/divide controller for EX: sequences the external multiplier and divider,
// owns architectural HI/LO and requests EX stalls while a multi-cycle op is in flight.
module md_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        busy,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait, StDone} state_e;

  localparam logic [3:0] MulLatCnt = 4'(MUL_LAT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sgn_d     = sgn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stallreq  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (op_valid && !flush) begin
          // Only mul/div ops (op[2]==0) hold EX; MTHI/MTLO retire in one cycle.
          stallreq = !op[2];
          unique case (op)
            3'd0, 3'd1: begin
              opa_d   = src_a;
              opb_d   = src_b;
              sgn_d   = (op == 3'd0);
              cnt_d   = MulLatCnt;
              state_d = StMulWait;
            end
            3'd2, 3'd3: begin
              if (src_b != 32'd0) begin
                opa_d   = src_a;
                opb_d   = src_b;
                sgn_d   = (op == 3'd2);
                state_d = StDivWait;
              end else begin
                hi_d    = src_a;
                lo_d    = 32'hFFFF_FFFF;
                state_d = StDone;
              end
            end
            3'd4:    hi_d = src_a;
            3'd5:    lo_d = src_a;
            default: ;
          endcase
        end
      end
      StMulWait: begin
        stallreq = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDivWait: begin
        stallreq  = 1'b1;
        div_start = !div_ready;
        if (flush) begin
          div_annul = 1'b1;
          state_d   = StIdle;
        end else if (div_ready) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          state_d = StDone;
        end
      end
      StDone: begin
        // EX advances this cycle; the op still visible in EX is not re-issued.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign mul_signed = sgn_q;
  assign mul_ina    = opa_q;
  assign mul_inb    = opb_q;
  assign div_signed = sgn_q;
  assign div_opa    = opa_q;
  assign div_opb    = opb_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized scoreboard bench for md_ctrl with behavioural multiplier/divider models.
module tb_md_ctrl;

  localparam int unsigned MulLat = 2;

  logic        clk = 1'b0;
  logic        rst, flush, op_valid;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_ina, mul_inb, div_opa, div_opb, hi, lo;
  logic [63:0] mul_result, div_result;

  md_ctrl #(.MUL_LAT(MulLat)) dut (
    .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .stallreq(stallreq), .busy(busy),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
    .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    return x * y;
  endfunction

  // Returns {remainder, quotient}; truncating division, remainder takes dividend sign.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] x, y, q, r;
    x = s ? {{32{a[31]}}, a} : {32'd0, a};
    y = s ? {{32{b[31]}}, b} : {32'd0, b};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Fixed-latency multiplier model
  logic [63:0] mpipe [MulLat];
  always @(posedge clk) begin
    mpipe[0] <= mul_ref(mul_ina, mul_inb, mul_signed);
    for (int i = 1; i < MulLat; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_result = mpipe[MulLat-1];

  // Iterative divider model: ready div_lat cycles after the first start cycle
  int          div_lat = 33;
  logic        dbusy = 1'b0;
  int          dcnt = 0;
  logic [63:0] dres = 64'd0;
  always @(posedge clk) begin
    if (rst || div_annul || div_ready) begin
      dbusy <= 1'b0;
    end else if (!dbusy && div_start) begin
      dbusy <= 1'b1;
      dcnt  <= 1;
      dres  <= div_ref(div_opa, div_opb, div_signed);
    end else if (dbusy) begin
      dcnt <= dcnt + 1;
    end
  end
  assign div_ready  = dbusy && (dcnt == div_lat);
  assign div_result = dres;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
    int          starts;
    logic        chk_sgn;
    logic        sgn;
  } exp_t;
  exp_t sbq[$];

  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;

  // Monitor: a completed op shows as DONE (busy, not stalling); MTHI/MTLO show one cycle later.
  initial begin
    int   scnt, dsc;
    logic mt_prev;
    exp_t e;
    scnt = 0; dsc = 0; mt_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        scnt = 0; dsc = 0; mt_prev = 1'b0;
      end else begin
        if ((busy && !stallreq) || mt_prev) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow: got completion expected none");
          end else begin
            e = sbq.pop_front();
            chk("hi", hi, e.hi);
            chk("lo", lo, e.lo);
            chk("stall_cycles", scnt, e.stall);
            chk("div_start_cycles", dsc, e.starts);
            if (e.chk_sgn) begin
              chk("mul_signed", mul_signed, e.sgn);
              chk("div_signed", div_signed, e.sgn);
            end
          end
          scnt = 0; dsc = 0;
        end
        if (stallreq) scnt++;
        if (div_start) dsc++;
        if (!busy && !stallreq) begin scnt = 0; dsc = 0; end
        mt_prev = !busy && op_valid && !flush && (op inside {3'd4, 3'd5});
      end
    end
  end

  // Present an op in EX and hold it until EX advances (a cycle ending with stallreq low).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] v;
    logic        s;
    int          n;
    e = '{hi: ref_hi, lo: ref_lo, stall: 0, starts: 0, chk_sgn: 1'b0, sgn: 1'b0};
    case (o)
      3'd0, 3'd1: begin
        v = mul_ref(a, b, o == 3'd0);
        e = '{hi: v[63:32], lo: v[31:0], stall: MulLat + 2, starts: 0,
              chk_sgn: 1'b1, sgn: (o == 3'd0)};
      end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          e = '{hi: a, lo: 32'hFFFF_FFFF, stall: 1, starts: 0, chk_sgn: 1'b0, sgn: 1'b0};
        end else begin
          v = div_ref(a, b, o == 3'd2);
          e = '{hi: v[63:32], lo: v[31:0], stall: div_lat + 2, starts: div_lat,
                chk_sgn: 1'b1, sgn: (o == 3'd2)};
        end
      end
      3'd4:    e.hi = a;
      3'd5:    e.lo = a;
      default: ;
    endcase
    if (o <= 3'd5) begin
      ref_hi = e.hi;
      ref_lo = e.lo;
      sbq.push_back(e);
    end
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n = 0;
    do begin
      @(negedge clk);
      s = stallreq;
      @(posedge clk);
      #1;
      n++;
    end while (s && n < 300);
    if (s) begin
      total++; bad++;
      $display("FAIL op_timeout: got stall after %0d cycles expected release", n);
    end
    op_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_div_annul", div_annul, 1'b0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_mul_ina", mul_ina, 32'd0);
    chk("rst_mul_inb", mul_inb, 32'd0);
    chk("rst_mul_signed", mul_signed, 1'b0);
    chk("rst_div_opa", div_opa, 32'd0);
    chk("rst_div_opb", div_opb, 32'd0);
    chk("rst_div_signed", div_signed, 1'b0);
    @(posedge clk); #1;

    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    div_lat = 33;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd3, 32'd5, 32'd0);

    // Flush 10 cycles into DIV_WAIT
    op_valid = 1'b1; op = 3'd2; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_annul_on", div_annul, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    chk("flush_annul_off", div_annul, 1'b0);
    chk("flush_stallreq", stallreq, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_hi", hi, ref_hi);
    chk("flush_lo", lo, ref_lo);
    @(posedge clk); #1;

    issue(3'd4, 32'h1234, 32'd0);
    issue(3'd5, 32'h5678, 32'd0);
    issue(3'd1, 32'h1_0000, 32'h1_0000);

    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom();
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFF_FFFF;
      div_lat = $urandom_range(1, 40);
      issue(ro, ra, rb);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    chk("final_hi", hi, ref_hi);
    chk("final_lo", lo, ref_lo);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the EX stage. It sequences the external fixed-latency multiplier and the iterative start/ready divider, owns the architectural HI/LO registers, and raises the EX stall request while a multi-cycle operation is in flight. It sits beside the ALU in EX. The EX input register holds the instruction stable while `stallreq` is high.

## Interface

Parameters:
- `MUL_LAT`, default 2: cycles from operands presented to the multiplier until `mul_result` is valid. Legal range is 1..15.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `flush` in 1: annuls the op currently in EX and any in-flight op.
- `op_valid` in 1: EX holds a mul/div/HI-LO op this cycle.
- `op` in 3: operation code.
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
  - 6 and 7 are no-ops.
- `src_a`, `src_b` in 32: rs and rt operand values.
- `stallreq` out 1: requests an EX stall.
- `busy` out 1: high when state ≠ IDLE.
- `mul_signed` out 1, `mul_ina` out 32, `mul_inb` out 32: multiplier operands.
- `mul_result` in 64: multiplier product {hi, lo}.
- `div_start` out 1, `div_signed` out 1, `div_opa` out 32, `div_opb` out 32, `div_annul` out 1: divider control and operands.
- `div_ready` in 1: divider result valid.
- `div_result` in 64: [63:32] remainder, [31:0] quotient.
- `hi` out 32, `lo` out 32: architectural HI/LO, registered.

## Operation

States: IDLE, MUL_WAIT, DIV_WAIT, DONE.

Operand latches `opa_r`, `opb_r` and `sgn_r` are captured on issue. They drive `mul_*` and `div_*` continuously.

Issue happens in IDLE when `op_valid=1` and `flush=0`:
- **MULT/MULTU**: latch operands; `sgn_r = (op==0)`; load `cnt = MUL_LAT`; go to MUL_WAIT.
- **DIV/DIVU with `src_b≠0`**: latch operands; `sgn_r = (op==2)`; go to DIV_WAIT.
- **DIV/DIVU with `src_b==0`**: write `HI <= src_a` and `LO <= 32'hFFFF_FFFF`; go to DONE.
- **MTHI / MTLO**: write `HI` or `LO` from `src_a` at this edge; stay in IDLE; no stall.
- **op 6 or 7**: no action.

MUL_WAIT:
- `cnt` decrements each cycle.
- In the cycle where `cnt==0`: capture `{HI,LO} <= mul_result`, then go to DONE.

DIV_WAIT:
- `div_start = !div_ready`.
- When `div_ready=1`: capture `HI <= div_result[63:32]` and `LO <= div_result[31:0]`, then go to DONE.

DONE:
- `stallreq=0`, so EX advances at the end of this cycle.
- Next state is IDLE unconditionally.
- The op held in EX during DONE is not re-issued.

`stallreq` is combinational: high when (IDLE ∧ `op_valid` ∧ ¬`flush` ∧ op∈{0,1,2,3}) ∨ MUL_WAIT ∨ DIV_WAIT.

`flush`:
- Has priority over everything.
- In MUL_WAIT or DIV_WAIT: abort, with no HI/LO write, and go to IDLE.
- Leaving DIV_WAIT by flush pulses `div_annul=1` for exactly that one cycle.
- In DONE: go to IDLE. The HI/LO write has already happened and is kept.

Multiplier sign handling belongs to the multiplier. Only `mul_signed=sgn_r` is driven.

## Timing

Reset values:
- State IDLE; `cnt=0`.
- `hi=lo=0`; `opa_r=opb_r=0`; `sgn_r=0`.
- Hence `mul_*` and `div_opa`/`div_opb`/`div_signed` are 0.
- `stallreq=busy=div_start=div_annul=0`.
- Reset mid-operation drops the op with no HI/LO write. The divider is reset by the same `rst`.

MULT issued at cycle T:
- `stallreq` is high for T..T+1+MUL_LAT.
- HI/LO is written at the end of T+1+MUL_LAT.
- DONE occurs at T+2+MUL_LAT. With MUL_LAT=2, the op occupies EX for 5 cycles.

DIV issued at T with the divider asserting `div_ready` at cycle R:
- `div_start` is high for T+1..R−1 and low at R.
- `stallreq` is high for T..R.
- HI/LO is written at the end of R; DONE is R+1.

Divide by zero: `stallreq` is high only in T; DONE is T+1.

MTHI/MTLO: zero stall; the new value is visible on `hi`/`lo` at T+1.

An op entering EX in the cycle after DONE issues normally, giving back-to-back ops.

## Test plan

- **Signed multiply**: reset, then MULT with a=0xFFFF_FFFE (−2), b=3. Required: `stallreq` high for 4 cycles; then `hi=0xFFFF_FFFF`, `lo=0xFFFF_FFFA`; DONE in cycle 5.
- **Unsigned multiply**: MULTU with a=0xFFFF_FFFF, b=2. Required: `mul_signed=0`; `hi=1`, `lo=0xFFFF_FFFE`.
- **Signed divide**: DIV with a=−7, b=2, against a divider model with `div_ready` 33 cycles after start. Required: `lo=0xFFFF_FFFD`, `hi=0xFFFF_FFFF`; `div_start` drops in the ready cycle; `stallreq` is low exactly one cycle later.
- **Divide by zero**: DIVU with a=5, b=0. Required: `div_start` never asserts; `hi=5`, `lo=0xFFFF_FFFF`; one stall cycle.
- **Flush mid-divide**: flush asserted 10 cycles into DIV_WAIT. Required: `div_annul` pulses for 1 cycle; HI/LO unchanged; next cycle is IDLE with `stallreq=0`.
- **Back-to-back**: MTHI 0x1234, then MTLO 0x5678, then MULTU with a=b=0x10000. Required: no stall for the MT ops; final `hi=1`, `lo=0`.
